// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue between the BIU and the pre-decoder.
// Optional `PREFETCH_PC_EN adds q_pc, the code address of the head byte.
module prefetch_queue #(
   parameter int DEPTH = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        flush,
   input  logic [15:0] flush_addr,
   output logic        fetch_req,
   output logic [15:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [15:0] fetch_data,
   input  logic [2:0]  consume,
   output logic [3:0]  q_len,
   output logic [7:0]  q0,
   output logic [7:0]  q1,
   output logic [7:0]  q2
`ifdef PREFETCH_PC_EN
   ,
   output logic [15:0] q_pc
`endif
);

   typedef logic [2:0] idx_t;

   // Handshake: fetch_req is a level that stays high with fetch_addr stable
   // until the single-cycle fetch_ack, which carries fetch_data and ends it.
   logic [7:0]  mem   [DEPTH];
   logic [7:0]  mem_n [DEPTH];
   idx_t        head, tail, head_n, tail_n;
   logic        drop_next, drop_n, req_n;
   logic [15:0] addr_n;
   logic [3:0]  cons, len_after, room, n_app, n_wr, len_n;
   logic [7:0]  wr_b0, q0_n, q1_n, q2_n;
   logic        ack_take;

   function automatic idx_t wrap_add(input idx_t base, input logic [3:0] inc);
      logic [4:0] s;
      s = {2'b00, base} + {1'b0, inc};
      if (s >= 5'(DEPTH)) s = s - 5'(DEPTH);
      return s[2:0];
   endfunction

   always_comb begin
      cons      = (4'(consume) > q_len) ? q_len : 4'(consume);
      ack_take  = fetch_ack && !flush && !drop_next;
      n_app     = ack_take ? (fetch_addr[0] ? 4'd1 : 4'd2) : 4'd0;
      len_after = q_len - cons;
      room      = 4'(DEPTH) - len_after;
      n_wr      = (n_app > room) ? room : n_app;
      // An odd address means the wanted byte sits in the high half of the word.
      wr_b0     = fetch_addr[0] ? fetch_data[15:8] : fetch_data[7:0];

      mem_n = mem;
      if (n_wr >= 4'd1) mem_n[tail] = wr_b0;
      if (n_wr >= 4'd2) mem_n[wrap_add(tail, 4'd1)] = fetch_data[15:8];

      if (flush) begin
         head_n = tail;
         tail_n = tail;
         len_n  = 4'd0;
         addr_n = flush_addr;
         req_n  = 1'b0;
         drop_n = fetch_req && !fetch_ack;
      end else begin
         head_n = wrap_add(head, cons);
         tail_n = wrap_add(tail, n_wr);
         len_n  = len_after + n_wr;
         addr_n = fetch_addr;
         drop_n = drop_next;
         if (fetch_ack) begin
            drop_n = 1'b0;
            if (!drop_next) addr_n = {fetch_addr[15:1] + 15'd1, 1'b0};
         end
         req_n = (fetch_req && !fetch_ack) || ((4'(DEPTH) - len_n) >= 4'd2);
      end

      q0_n = (len_n > 4'd0) ? mem_n[head_n] : 8'h00;
      q1_n = (len_n > 4'd1) ? mem_n[wrap_add(head_n, 4'd1)] : 8'h00;
      q2_n = (len_n > 4'd2) ? mem_n[wrap_add(head_n, 4'd2)] : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (ce) mem <= mem_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         q_len      <= '0;
         q0         <= '0;
         q1         <= '0;
         q2         <= '0;
         fetch_req  <= 1'b0;
         fetch_addr <= '0;
         drop_next  <= 1'b0;
      end else if (ce) begin
         head       <= head_n;
         tail       <= tail_n;
         q_len      <= len_n;
         q0         <= q0_n;
         q1         <= q1_n;
         q2         <= q2_n;
         fetch_req  <= req_n;
         fetch_addr <= addr_n;
         drop_next  <= drop_n;
      end
   end

`ifdef PREFETCH_PC_EN
   // The clamped consume is zero on an empty queue, so the PC holds there.
   always_ff @(posedge clk) begin
      if (reset)     q_pc <= '0;
      else if (ce)   q_pc <= flush ? flush_addr : q_pc + 16'(cons);
   end
`endif

endmodule
